// File: rtl/bitscan_pkg.sv
// Shared types and helpers for the sequential bit-scan encoder.
package bitscan_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [0:0] {IDLE, EMIT} state_t;

    // Return vec with bit idx forced to zero.
    function automatic logic [MAX_WIDTH-1:0] clear_bit(input logic [MAX_WIDTH-1:0] vec,
                                                      input logic [5:0]           idx);
        logic [MAX_WIDTH-1:0] r;
        r      = vec;
        r[idx] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/bitscan_encoder_prio_enc.sv
// Combinational priority encoder: index of the highest- or lowest-priority set bit.
module prio_enc #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned IW       = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IW-1:0]    idx,
    output logic             hit
);

    // The last matching bit in scan order wins, so scan towards the priority end.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (vec[i]) idx = IW'(i);
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (vec[i]) idx = IW'(i);
            end
        end
    end

    assign hit = |vec;

endmodule

// File: rtl/bitscan_encoder.sv
// Accepts a request vector and emits the index of every set bit, one per handshake.
module bitscan_encoder
    import bitscan_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned IW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [IW-1:0]    out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [IW:0]      out_seq
);

    localparam int unsigned SW = IW + 1;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     vec_q, vec_d;
    logic                 none_q, none_d;
    logic [SW-1:0]        seq_q, seq_d;
    logic [MAX_WIDTH-1:0] vec_wide;
    logic [IW-1:0]        enc_idx;
    logic                 enc_hit;
    logic                 emit, single, beat;

    prio_enc #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_enc (
        .vec (vec_q),
        .idx (enc_idx),
        .hit (enc_hit)
    );

    always_comb begin
        vec_wide              = '0;
        vec_wide[WIDTH-1:0]   = vec_q;
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        none_d  = none_q;
        seq_d   = seq_q;

        emit   = (state_q == EMIT);
        // At most one bit set: clearing the lowest set bit leaves nothing.
        single = ((vec_q & (vec_q - WIDTH'(1))) == '0);

        out_vld  = emit;
        out_last = emit & (none_q | single);
        out_none = emit & none_q;
        out_seq  = emit ? seq_q : '0;
        out_idx  = (emit && enc_hit && !none_q) ? enc_idx : '0;

        beat   = emit & out_rdy;
        in_rdy = !rst & (!emit | (beat & out_last));

        if (beat) begin
            vec_d = WIDTH'(clear_bit(vec_wide, 6'(enc_idx)));
            seq_d = seq_q + SW'(1);
            if (out_last) state_d = IDLE;
        end

        if (in_vld && in_rdy) begin
            vec_d   = in_vec;
            none_d  = (in_vec == '0);
            seq_d   = '0;
            state_d = EMIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            none_q  <= 1'b0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            none_q  <= none_d;
            seq_q   <= seq_d;
        end
    end

endmodule

// File: tb/tb_bitscan_encoder.sv
// Self-checking bench: three encoder configurations against a beat-list reference model.
module tb_bitscan_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_vld [3];
    logic       out_rdy [3];
    logic [7:0] in_vec [3];
    logic       in_rdy_a [3];
    logic       out_vld_a [3];
    logic       out_last_a [3];
    logic       out_none_a [3];
    logic [2:0] out_idx_a [3];
    logic [3:0] out_seq_a [3];

    int checks   = 0;
    int failures = 0;

    // Model entries: idx[7:0], seq[15:8], last[16], none[17].
    int expq [3][$];
    // DUT-observed accepted beats: idx[7:0], last[8], none[9].
    int obs [3][$];
    int gen_q [$];
    int exp_l [$];
    bit acc [3];

    always #5 clk = ~clk;

    bitscan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
        .clk(clk), .rst(rst), .in_vld(in_vld[0]), .in_rdy(in_rdy_a[0]), .in_vec(in_vec[0]),
        .out_vld(out_vld_a[0]), .out_rdy(out_rdy[0]), .out_idx(out_idx_a[0]),
        .out_last(out_last_a[0]), .out_none(out_none_a[0]), .out_seq(out_seq_a[0])
    );

    bitscan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
        .clk(clk), .rst(rst), .in_vld(in_vld[1]), .in_rdy(in_rdy_a[1]), .in_vec(in_vec[1]),
        .out_vld(out_vld_a[1]), .out_rdy(out_rdy[1]), .out_idx(out_idx_a[1]),
        .out_last(out_last_a[1]), .out_none(out_none_a[1]), .out_seq(out_seq_a[1])
    );

    bitscan_encoder #(.WIDTH(5), .MSB_FIRST(1'b1)) u_msb5 (
        .clk(clk), .rst(rst), .in_vld(in_vld[2]), .in_rdy(in_rdy_a[2]), .in_vec(in_vec[2][4:0]),
        .out_vld(out_vld_a[2]), .out_rdy(out_rdy[2]), .out_idx(out_idx_a[2]),
        .out_last(out_last_a[2]), .out_none(out_none_a[2]), .out_seq(out_seq_a[2])
    );

    function automatic int w_of(input int k);
        return (k == 2) ? 5 : 8;
    endfunction

    function automatic bit msb_of(input int k);
        return (k != 1);
    endfunction

    // Expected beat list for one vector: set bits in priority order, or one "none" beat.
    function automatic void gen(input logic [7:0] v, input int w, input bit msb);
        int n;
        n = 0;
        gen_q.delete();
        for (int s = 0; s < w; s++) begin
            int j;
            j = msb ? (w - 1 - s) : s;
            if (v[j]) begin
                gen_q.push_back(j | (n << 8));
                n++;
            end
        end
        if (n == 0) gen_q.push_back((1 << 16) | (1 << 17));
        else gen_q[n-1] = gen_q[n-1] | (1 << 16);
    endfunction

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut=%0d got=%0d want=%0d t=%0t", name, k, act, exp, $time);
        end
    endtask

    // Reference model: advance on every clock edge.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int  n;
            bit  rdy;
            acc[k] = 1'b0;
            if (rst) begin
                expq[k].delete();
            end else begin
                if (out_vld_a[k] && out_rdy[k])
                    obs[k].push_back(int'(out_idx_a[k]) | (int'(out_last_a[k]) << 8)
                                     | (int'(out_none_a[k]) << 9));
                n   = expq[k].size();
                rdy = (n == 0) || (out_rdy[k] && n == 1);
                if (n > 0 && out_rdy[k]) void'(expq[k].pop_front());
                if (in_vld[k] && rdy) begin
                    gen(in_vec[k], w_of(k), msb_of(k));
                    foreach (gen_q[i]) expq[k].push_back(gen_q[i]);
                    acc[k] = 1'b1;
                end
            end
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int n;
            int e;
            n = expq[k].size();
            chk("in_rdy", k, int'(in_rdy_a[k]),
                int'(!rst && (n == 0 || (out_rdy[k] && n == 1))));
            chk("out_vld", k, int'(out_vld_a[k]), int'(n > 0));
            if (n > 0) begin
                e = expq[k][0];
                chk("out_idx", k, int'(out_idx_a[k]), e & 255);
                chk("out_seq", k, int'(out_seq_a[k]), (e >> 8) & 255);
                chk("out_last", k, int'(out_last_a[k]), (e >> 16) & 1);
                chk("out_none", k, int'(out_none_a[k]), (e >> 17) & 1);
            end
        end
    end

    task automatic send(input int k, input logic [7:0] v, output int cyc);
        in_vld[k] = 1'b1;
        in_vec[k] = v;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!acc[k] && cyc < 100);
        chk("send_accepted", k, int'(acc[k]), 1);
        in_vld[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (expq[k].size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", k, expq[k].size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input int k, input string name);
        chk({name, "_len"}, k, obs[k].size(), exp_l.size());
        foreach (exp_l[i]) begin
            if (i < obs[k].size()) chk(name, k, obs[k][i], exp_l[i]);
        end
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < 3; k++) begin
            in_vld[k]  = 1'b0;
            in_vec[k]  = '0;
            out_rdy[k] = 1'b1;
        end

        // Pin the model with hand-derived values.
        gen(8'hA4, 8, 1'b1);
        chk("model_a4_msb_cnt", 0, gen_q.size(), 3);
        chk("model_a4_msb_first", 0, gen_q[0], 7);
        chk("model_a4_msb_last", 0, gen_q[2], 66050);
        gen(8'hA4, 8, 1'b0);
        chk("model_a4_lsb_first", 1, gen_q[0], 2);
        gen(8'h00, 8, 1'b1);
        chk("model_zero", 0, gen_q[0], 196608);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_vld", 0, int'(out_vld_a[0]), 0);
        chk("rst_out_last", 0, int'(out_last_a[0]), 0);
        chk("rst_out_none", 0, int'(out_none_a[0]), 0);
        chk("rst_out_seq", 0, int'(out_seq_a[0]), 0);
        chk("rst_out_idx", 0, int'(out_idx_a[0]), 0);
        chk("rst_in_rdy", 0, int'(in_rdy_a[0]), 1);

        obs[0].delete();
        send(0, 8'hA4, cyc);
        @(negedge clk);
        chk("t1_latency_vld", 0, int'(out_vld_a[0]), 1);
        chk("t1_first_idx", 0, int'(out_idx_a[0]), 7);
        wait_idle(0);
        exp_l = '{7, 5, 258};
        check_log(0, "t1_msb_seq");

        obs[1].delete();
        send(1, 8'hA4, cyc);
        wait_idle(1);
        exp_l = '{2, 5, 263};
        check_log(1, "t2_lsb_seq");

        obs[0].delete();
        send(0, 8'h00, cyc);
        wait_idle(0);
        exp_l = '{768};
        check_log(0, "t3_zero");
        chk("t3_idle_after", 0, int'(out_vld_a[0]), 0);

        obs[0].delete();
        send(0, 8'hFF, cyc);
        begin
            int n;
            n = 0;
            while (expq[0].size() != 0 && n < 400) begin
                out_rdy[0] = 1'($urandom % 2);
                @(posedge clk);
                #1;
                n++;
            end
        end
        out_rdy[0] = 1'b1;
        wait_idle(0);
        exp_l = '{7, 6, 5, 4, 3, 2, 1, 256};
        check_log(0, "t4_ones_stall");

        obs[0].delete();
        send(0, 8'h81, cyc);
        send(0, 8'h10, cyc);
        chk("t5_b2b_accept_cycles", 0, cyc, 2);
        wait_idle(0);
        exp_l = '{7, 256, 260};
        check_log(0, "t5_b2b");

        obs[2].delete();
        send(2, 8'h13, cyc);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_vld_after_rst", 2, int'(out_vld_a[2]), 0);
        chk("t6_rdy_after_rst", 2, int'(in_rdy_a[2]), 1);
        exp_l = '{4};
        check_log(2, "t6_pre_rst");
        obs[2].delete();
        send(2, 8'h04, cyc);
        wait_idle(2);
        exp_l = '{258};
        check_log(2, "t6_post_rst");

        // Randomised traffic on all three configurations.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++) begin
                int r;
                r          = int'($urandom % 8);
                out_rdy[k] = ($urandom % 4) != 0;
                in_vld[k]  = 1'($urandom % 2);
                in_vec[k]  = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            in_vld[k]  = 1'b0;
            out_rdy[k] = 1'b1;
        end
        for (int k = 0; k < 3; k++) wait_idle(k);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
